// File: rtl/bcd_pkg.sv
// Shared BCD definitions: FSM states, digit width and saturation helpers
// used by the serial converter and the other BCD-input blocks.
package bcd_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int unsigned BCD_DIGIT_W = 4;

    // Packed BCD word with every digit set to 9 (up to 16 digits).
    function automatic logic [63:0] bcd_all_nines(input int unsigned digits);
        logic [63:0] r;
        r = '0;
        for (int unsigned i = 0; i < digits; i++) begin
            r = (r << BCD_DIGIT_W) | 64'h9;
        end
        return r;
    endfunction

    // Largest binary value representable in the given number of digits.
    function automatic logic [63:0] bcd_max_value(input int unsigned digits);
        logic [63:0] r;
        r = 64'd1;
        for (int unsigned i = 0; i < digits; i++) begin
            r = r * 64'd10;
        end
        return r - 64'd1;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more
// so that the following left shift carries correctly into the next digit.
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] d,
    output logic [BCD_DIGIT_W-1:0] q
);

    always_comb begin
        q = d;
        if (d >= BCD_DIGIT_W'(5)) begin
            q = d + BCD_DIGIT_W'(3);
        end
    end

endmodule

// File: rtl/bin_to_bcd_serial.sv
// Serial binary-to-BCD converter (shift-and-add-3, one bit per clock) with
// saturation to all-nines and an overflow flag for out-of-range operands.
module bin_to_bcd_serial
    import bcd_pkg::*;
#(
    parameter int unsigned BIN_WIDTH = 14,
    parameter int unsigned DIGITS    = 4
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          START,
    input  logic [BIN_WIDTH-1:0]          BIN_IN,
    output logic                          BUSY,
    output logic                          DONE,
    output logic [BCD_DIGIT_W*DIGITS-1:0] BCD_OUT,
    output logic                          OVERFLOW
);

    localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_WIDTH + 1);
    localparam logic [BCD_W-1:0] SAT_VALUE = BCD_W'(bcd_all_nines(DIGITS));
    localparam logic [63:0] MAX_VALUE = bcd_max_value(DIGITS);

    state_t               state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [BIN_WIDTH-1:0] bin_sr, bin_n;
    logic [BCD_W-1:0]     scratch, scratch_n;
    logic [BCD_W-1:0]     adj, scratch_shift;
    logic                 ovf_latch, latch_n;
    logic [BCD_W-1:0]     bcd_n;
    logic                 ovf_n, done_n;

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adjust u_adj (
            .d (scratch[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .q (adj[i*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // The adjusted MSB falls off the top; saturation covers out-of-range inputs.
    assign scratch_shift = (adj << 1) | BCD_W'(bin_sr[BIN_WIDTH-1]);

    assign BUSY = (state != IDLE);

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bin_n     = bin_sr;
        scratch_n = scratch;
        latch_n   = ovf_latch;
        bcd_n     = BCD_OUT;
        ovf_n     = OVERFLOW;
        done_n    = 1'b0;
        case (state)
            IDLE: begin
                if (START) begin
                    state_n   = SHIFT;
                    bin_n     = BIN_IN;
                    scratch_n = '0;
                    cnt_n     = CNT_W'(BIN_WIDTH);
                    latch_n   = (64'(BIN_IN) > MAX_VALUE);
                end
            end
            SHIFT: begin
                scratch_n = scratch_shift;
                bin_n     = bin_sr << 1;
                cnt_n     = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_n = IDLE;
                    bcd_n   = ovf_latch ? SAT_VALUE : scratch_shift;
                    ovf_n   = ovf_latch;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            cnt       <= '0;
            bin_sr    <= '0;
            scratch   <= '0;
            ovf_latch <= 1'b0;
            BCD_OUT   <= '0;
            OVERFLOW  <= 1'b0;
            DONE      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bin_sr    <= bin_n;
            scratch   <= scratch_n;
            ovf_latch <= latch_n;
            BCD_OUT   <= bcd_n;
            OVERFLOW  <= ovf_n;
            DONE      <= done_n;
        end
    end

endmodule
